// File: rtl/prll_2_srl_conv_pkg.sv
// Shared types for the parallel-to-serial stage: FSM state encoding and width limits.
// The serial-to-parallel stage imports the same state encoding.
package prll_2_srl_conv_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;

  localparam int DATA_W_DEF = 4;
  localparam int MIN_DATA_W = 2;

endpackage

// File: rtl/prll_2_srl_conv_if.sv
// Word-in / bit-out bundle of the parallel-to-serial stage.
// The slave modport is the converter's view; the master modport is the environment's view.
interface prll_2_srl_conv_if #(
  parameter int DATA_W = prll_2_srl_conv_pkg::DATA_W_DEF
);
  logic [DATA_W-1:0] prll_in;
  logic              prll_valid_i;
  logic              prll_ready_o;
  logic              srl_o;
  logic              srl_valid_o;
  logic              frame_o;
  logic              busy_o;

  modport slave (
    input  prll_in, prll_valid_i,
    output prll_ready_o, srl_o, srl_valid_o, frame_o, busy_o
  );

  modport master (
    output prll_in, prll_valid_i,
    input  prll_ready_o, srl_o, srl_valid_o, frame_o, busy_o
  );
endinterface

// File: rtl/prll_2_srl_conv.sv
// Parallel-to-serial converter: one DATA_W-bit word per handshake, one bit per clock out,
// with a one-word hold register so consecutive words leave without a gap.
module prll_2_srl_conv
  import prll_2_srl_conv_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset_n,
  prll_2_srl_conv_if.slave bus
);

  localparam int CNT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_W - 1);

  if (DATA_W < MIN_DATA_W) begin : g_bad_width
    $error("prll_2_srl_conv: DATA_W must be at least 2");
  end

  state_e            state_q, state_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [DATA_W-1:0] hold_q, hold_d;
  logic              hold_full_q, hold_full_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              ready_q, ready_d;
  logic              valid_q, valid_d;
  logic              frame_q, frame_d;
  logic              busy_q, busy_d;
  logic              accept_s;

  // Advance the shifter so the next bit to send sits in the output flop.
  function automatic logic [DATA_W-1:0] shift_one(input logic [DATA_W-1:0] v);
    if (MSB_FIRST) begin
      return {v[DATA_W-2:0], 1'b0};
    end else begin
      return {1'b0, v[DATA_W-1:1]};
    end
  endfunction

  assign accept_s = bus.prll_valid_i & ready_q;

  // State, datapath and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      shift_q     <= {DATA_W{1'b0}};
      hold_q      <= {DATA_W{1'b0}};
      hold_full_q <= 1'b0;
      cnt_q       <= {CNT_W{1'b0}};
      ready_q     <= 1'b0;
      valid_q     <= 1'b0;
      frame_q     <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      cnt_q       <= cnt_d;
      ready_q     <= ready_d;
      valid_q     <= valid_d;
      frame_q     <= frame_d;
      busy_q      <= busy_d;
    end
  end

  // Next-state logic; on the last bit a held word beats a fresh one since ready is low then.
  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    cnt_d       = cnt_q;
    valid_d     = valid_q;
    frame_d     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          shift_d = bus.prll_in;
          cnt_d   = {CNT_W{1'b0}};
          state_d = ST_SHIFT;
          valid_d = 1'b1;
          frame_d = 1'b1;
        end else begin
          shift_d = {DATA_W{1'b0}};
          valid_d = 1'b0;
        end
      end
      ST_SHIFT: begin
        if (cnt_q == LAST_CNT) begin
          if (hold_full_q) begin
            shift_d     = hold_q;
            hold_full_d = 1'b0;
            cnt_d       = {CNT_W{1'b0}};
            frame_d     = 1'b1;
          end else if (accept_s) begin
            shift_d = bus.prll_in;
            cnt_d   = {CNT_W{1'b0}};
            frame_d = 1'b1;
          end else begin
            state_d = ST_IDLE;
            shift_d = {DATA_W{1'b0}};
            cnt_d   = {CNT_W{1'b0}};
            valid_d = 1'b0;
          end
        end else begin
          shift_d = shift_one(shift_q);
          cnt_d   = cnt_q + CNT_W'(1);
          if (accept_s) begin
            hold_d      = bus.prll_in;
            hold_full_d = 1'b1;
          end else begin
            hold_full_d = hold_full_q;
          end
        end
      end
      default: begin
        state_d     = ST_IDLE;
        shift_d     = {DATA_W{1'b0}};
        hold_full_d = 1'b0;
        cnt_d       = {CNT_W{1'b0}};
        valid_d     = 1'b0;
      end
    endcase
    ready_d = ~hold_full_d;
    busy_d  = (state_d == ST_SHIFT) | hold_full_d;
  end

  if (MSB_FIRST) begin : g_msb
    assign bus.srl_o = shift_q[DATA_W-1];
  end else begin : g_lsb
    assign bus.srl_o = shift_q[0];
  end

  assign bus.prll_ready_o = ready_q;
  assign bus.srl_valid_o  = valid_q;
  assign bus.frame_o      = frame_q;
  assign bus.busy_o       = busy_q;

endmodule

// File: tb/tb_prll_2_srl_conv.sv
// Directed and randomised bench for prll_2_srl_conv; dut_m is MSB-first, dut_l is LSB-first.
module tb_prll_2_srl_conv;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  prll_2_srl_conv_if #(.DATA_W(4)) bus_m ();
  prll_2_srl_conv_if #(.DATA_W(4)) bus_l ();

  prll_2_srl_conv #(.DATA_W(4), .MSB_FIRST(1'b1)) dut_m (
    .clk(clk), .reset_n(reset_n), .bus(bus_m)
  );
  prll_2_srl_conv #(.DATA_W(4), .MSB_FIRST(1'b0)) dut_l (
    .clk(clk), .reset_n(reset_n), .bus(bus_l)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Checks srl_o / srl_valid_o / frame_o of the MSB-first converter in one go.
  task automatic chk_out(input string tag, input logic s, input logic v, input logic f);
    chk({tag, ".srl"}, 32'(bus_m.srl_o), 32'(s));
    chk({tag, ".val"}, 32'(bus_m.srl_valid_o), 32'(v));
    chk({tag, ".frm"}, 32'(bus_m.frame_o), 32'(f));
  endtask

  initial begin
    logic [3:0] exp_bits;
    logic [3:0] acc;
    logic [3:0] d;
    logic [3:0] q[$];
    logic       v;
    logic       rdy_seen;
    int         nb;

    bus_m.prll_in = 4'h0; bus_m.prll_valid_i = 1'b0;
    bus_l.prll_in = 4'h0; bus_l.prll_valid_i = 1'b0;

    // 1: reset
    #10;
    chk_out("rst", 1'b0, 1'b0, 1'b0);
    chk("rst.rdy", 32'(bus_m.prll_ready_o), 32'd0);
    chk("rst.busy", 32'(bus_m.busy_o), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    chk("rel.rdy0", 32'(bus_m.prll_ready_o), 32'd0);
    tick();
    chk("rel.rdy1", 32'(bus_m.prll_ready_o), 32'd1);
    chk("rel.rdyl", 32'(bus_l.prll_ready_o), 32'd1);

    // 2: single word 1011
    bus_m.prll_in = 4'b1011; bus_m.prll_valid_i = 1'b1;
    tick();
    bus_m.prll_valid_i = 1'b0;
    chk_out("w1.b0", 1'b1, 1'b1, 1'b1);
    chk("w1.busy", 32'(bus_m.busy_o), 32'd1);
    tick(); chk_out("w1.b1", 1'b0, 1'b1, 1'b0);
    tick(); chk_out("w1.b2", 1'b1, 1'b1, 1'b0);
    tick(); chk_out("w1.b3", 1'b1, 1'b1, 1'b0);
    tick(); chk_out("w1.end", 1'b0, 1'b0, 1'b0);
    chk("w1.busy0", 32'(bus_m.busy_o), 32'd0);
    tick(); chk_out("w1.idle", 1'b0, 1'b0, 1'b0);

    // 3: back-to-back A then 5 with valid held
    bus_m.prll_in = 4'hA; bus_m.prll_valid_i = 1'b1;
    tick();
    chk_out("bb.b0", 1'b1, 1'b1, 1'b1);
    chk("bb.rdy0", 32'(bus_m.prll_ready_o), 32'd1);
    bus_m.prll_in = 4'h5;
    tick();
    bus_m.prll_valid_i = 1'b0;
    chk_out("bb.b1", 1'b0, 1'b1, 1'b0);
    chk("bb.rdy1", 32'(bus_m.prll_ready_o), 32'd0);
    tick(); chk_out("bb.b2", 1'b1, 1'b1, 1'b0);
    chk("bb.rdy2", 32'(bus_m.prll_ready_o), 32'd0);
    tick(); chk_out("bb.b3", 1'b0, 1'b1, 1'b0);
    chk("bb.rdy3", 32'(bus_m.prll_ready_o), 32'd0);
    exp_bits = 4'h5;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk_out($sformatf("bb.c%0d", i + 4), exp_bits[3 - i], 1'b1, (i == 0));
      chk($sformatf("bb.rdy%0d", i + 4), 32'(bus_m.prll_ready_o), 32'd1);
    end
    tick(); chk_out("bb.end", 1'b0, 1'b0, 1'b0);

    // 4: LSB-first word 0001
    bus_l.prll_in = 4'b0001; bus_l.prll_valid_i = 1'b1;
    tick();
    bus_l.prll_valid_i = 1'b0;
    exp_bits = 4'b0001;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("lsb.b%0d", i), 32'(bus_l.srl_o), 32'(exp_bits[i]));
      chk($sformatf("lsb.v%0d", i), 32'(bus_l.srl_valid_o), 32'd1);
      chk($sformatf("lsb.f%0d", i), 32'(bus_l.frame_o), 32'(i == 0));
      tick();
    end
    chk("lsb.end", 32'(bus_l.srl_valid_o), 32'd0);

    // 5: reset mid-word with the hold register full
    bus_m.prll_in = 4'hF; bus_m.prll_valid_i = 1'b1;
    tick();
    bus_m.prll_in = 4'hE;
    tick();
    bus_m.prll_valid_i = 1'b0;
    tick();
    chk_out("mr.b2", 1'b1, 1'b1, 1'b0);
    chk("mr.busy", 32'(bus_m.busy_o), 32'd1);
    reset_n = 1'b0;
    #1;
    chk_out("mr.rst", 1'b0, 1'b0, 1'b0);
    chk("mr.busy0", 32'(bus_m.busy_o), 32'd0);
    chk("mr.rdy0", 32'(bus_m.prll_ready_o), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk_out($sformatf("mr.q%0d", i), 1'b0, 1'b0, 1'b0);
    end
    chk("mr.rdy", 32'(bus_m.prll_ready_o), 32'd1);

    // 6: random words with random gaps, rebuilt by a bench-side deserializer
    v = 1'b0;
    nb = 0;
    acc = 4'h0;
    d = 4'h0;
    rdy_seen = bus_m.prll_ready_o;
    for (int i = 0; i < 230; i++) begin
      tick();
      if (v && rdy_seen) begin
        q.push_back(d);
        v = 1'b0;
      end
      if (bus_m.srl_valid_o) begin
        if (bus_m.frame_o) begin
          chk("rnd.align", 32'(nb), 32'd0);
          nb = 0;
        end
        acc = {acc[2:0], bus_m.srl_o};
        nb++;
        if (nb == 4) begin
          if (q.size() == 0) begin
            chk("rnd.extra", 32'(acc), 32'hFFFF_FFFF);
          end else begin
            chk("rnd.word", 32'(acc), 32'(q.pop_front()));
          end
          nb = 0;
        end
      end else begin
        chk("rnd.srl0", 32'(bus_m.srl_o), 32'd0);
      end
      if (!v && i < 200 && $urandom_range(0, 2) != 0) begin
        v = 1'b1;
        d = 4'($urandom);
      end
      bus_m.prll_in = d;
      bus_m.prll_valid_i = v;
      rdy_seen = bus_m.prll_ready_o;
    end
    chk("rnd.drained", 32'(q.size()), 32'd0);
    chk("rnd.idle", 32'(bus_m.busy_o), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
